// File: rtl/better_half_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : better_half_adder_4bit
//  Description : Unsigned WIDTH-bit ripple-carry adder, no carry-in.
//                Bit 0 is a half adder; bits 1..WIDTH-1 are carry-propagating
//                slices (two half adders plus an OR). {cout, s} = a + b.
//                The result is optionally registered (OUT_REG = 1, latency 1).
//  Revision    : 1.0  initial release
// ============================================================================
module better_half_adder_4bit #(
  parameter int WIDTH   = 4,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] s_o,
  output logic             cout_o
);

  // Per-bit propagate / generate and the ripple carry chain.
  // w_c[0] is tied low, so slice 0 degenerates into a plain half adder.
  logic [WIDTH-1:0] w_p;
  logic [WIDTH-1:0] w_g;
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;

  assign w_c[0] = 1'b0;

  // Explicit slice-by-slice ripple so the carry walks through every bit
  // exactly as a gate-level adder would (e.g. 1111 + 0001 toggles all bits).
  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
      // First half adder: operand bits.
      assign w_p[i] = a_i[i] ^ b_i[i];
      assign w_g[i] = a_i[i] & b_i[i];
      // Second half adder combines with incoming carry; OR merges the two
      // carry sources (they can never both be high).
      assign w_sum[i]  = w_p[i] ^ w_c[i];
      assign w_c[i+1]  = w_g[i] | (w_p[i] & w_c[i]);
    end
  endgenerate

  generate
    if (OUT_REG) begin : g_out_reg
      logic [WIDTH-1:0] s_q;
      logic [WIDTH-1:0] s_d;
      logic             cout_q;
      logic             cout_d;

      assign s_d    = w_sum;
      assign cout_d = w_c[WIDTH];

      // Output register: cleared by synchronous reset, else loads the sum.
      always_ff @(posedge clk) begin
        if (rst) begin
          s_q    <= '0;
          cout_q <= 1'b0;
        end else begin
          s_q    <= s_d;
          cout_q <= cout_d;
        end
      end

      assign s_o    = s_q;
      assign cout_o = cout_q;
    end else begin : g_out_comb
      // clk and rst stay on the port list for a uniform interface only.
      logic w_unused_ok;
      assign w_unused_ok = &{1'b0, clk, rst};

      assign s_o    = w_sum;
      assign cout_o = w_c[WIDTH];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_better_half_adder_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_better_half_adder_4bit
//  Description : Self-checking bench for better_half_adder_4bit
//                (WIDTH = 4, OUT_REG = 1). Expected values come from plain
//                integer addition of the applied operands.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_better_half_adder_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] a   = '0;
  logic [W-1:0] b   = '0;
  logic [W-1:0] s;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  better_half_adder_4bit #(
    .WIDTH   (W),
    .OUT_REG (1'b1)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .a_i    (a),
    .b_i    (b),
    .s_o    (s),
    .cout_o (cout)
  );

  always #5 clk = ~clk;

  // Reference: exact unsigned sum of the operands, carry in bit W.
  function automatic logic [W:0] ref_sum(input int unsigned x, input int unsigned y);
    int unsigned t;
    t = x + y;
    return t[W:0];
  endfunction

  // Apply inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic [W-1:0] av, input logic [W-1:0] bv, input logic rv);
    rst = rv;
    a   = av;
    b   = bv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(4'b1010, 4'b0101, 1'b1);
      checks++;
      if ({cout, s} !== 5'b0_0000) begin
        failures++;
        $display("FAIL reset[%0d]: got cout=%b s=%b, want cout=0 s=0000", k, cout, s);
      end
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] va [10];
    logic [W-1:0] vb [10];
    logic [W:0]   exp;
    va = '{4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0111, 4'b0100,
           4'b1111, 4'b0001, 4'b1111, 4'b0110};
    vb = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0011, 4'b0001,
           4'b0001, 4'b1111, 4'b0010, 4'b1111};
    for (int k = 0; k < 10; k++) begin
      step(va[k], vb[k], 1'b0);
      exp = ref_sum(va[k], vb[k]);
      checks++;
      if ({cout, s} !== exp) begin
        failures++;
        $display("FAIL directed a=%b b=%b: got cout=%b s=%b, want cout=%b s=%b",
                 va[k], vb[k], cout, s, exp[W], exp[W-1:0]);
      end
    end
  endtask

  task automatic test_max();
    step(4'b1111, 4'b1111, 1'b0);
    checks++;
    if ({cout, s} !== 5'b1_1110) begin
      failures++;
      $display("FAIL max 1111+1111: got cout=%b s=%b, want cout=1 s=1110", cout, s);
    end
  endtask

  task automatic test_reset_midstream();
    step(4'b1111, 4'b1111, 1'b1);
    checks++;
    if ({cout, s} !== 5'b0_0000) begin
      failures++;
      $display("FAIL midreset: got cout=%b s=%b, want cout=0 s=0000", cout, s);
    end
    step(4'b1111, 4'b1111, 1'b0);
    checks++;
    if ({cout, s} !== 5'b1_1110) begin
      failures++;
      $display("FAIL after_midreset: got cout=%b s=%b, want cout=1 s=1110", cout, s);
    end
  endtask

  // Outputs must hold between edges: glitch rst and change operands mid-cycle.
  task automatic test_hold();
    step(4'b0111, 4'b0011, 1'b0);
    rst = 1'b1;
    a   = 4'b1111;
    b   = 4'b1111;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({cout, s} !== 5'b0_1010) begin
      failures++;
      $display("FAIL hold: got cout=%b s=%b, want cout=0 s=1010", cout, s);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cout, s} !== 5'b1_1110) begin
      failures++;
      $display("FAIL hold_next: got cout=%b s=%b, want cout=1 s=1110", cout, s);
    end
  endtask

  task automatic test_exhaustive();
    logic [W:0] exp;
    int         bad;
    bad = 0;
    for (int x = 0; x < (1 << W); x++) begin
      for (int y = 0; y < (1 << W); y++) begin
        step(W'(x), W'(y), 1'b0);
        exp = ref_sum(x, y);
        checks++;
        if ({cout, s} !== exp) begin
          failures++;
          bad++;
          if (bad <= 8)
            $display("FAIL sweep a=%0d b=%0d: got %0d, want %0d", x, y, {cout, s}, exp);
        end
      end
    end
  endtask

  // Back-to-back random operands, a new result every cycle.
  task automatic test_back_to_back();
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   exp;
    for (int k = 0; k < 64; k++) begin
      ra = W'($urandom_range(0, (1 << W) - 1));
      rb = W'($urandom_range(0, (1 << W) - 1));
      step(ra, rb, 1'b0);
      exp = ref_sum(ra, rb);
      checks++;
      if ({cout, s} !== exp) begin
        failures++;
        $display("FAIL random a=%0d b=%0d: got %0d, want %0d", ra, rb, {cout, s}, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_max();
    test_reset_midstream();
    test_hold();
    test_exhaustive();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
